shared_reg_arbiter: RTL and testbench
=====================================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the shared register data width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports are clk and reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester write request.
REQ-007 The block SHALL have port lock, input, N_REQ bits: per-requester burst hold request, sampled with req.
REQ-008 The block SHALL have port wdata, input, N_REQ x WIDTH: per-requester write data.
REQ-009 The block SHALL have port gnt, output, N_REQ bits: registered one-hot grant (or zero) for the current cycle's write.
REQ-010 The block SHALL have port q, output, WIDTH bits: shared register contents.
REQ-011 The block SHALL have port q_valid, output, 1 bit: high when q was loaded on the last edge.

Function
REQ-012 Each rising clk edge, the block SHALL choose at most one winner and load q <= wdata[winner], gnt <= onehot(winner), q_valid <= 1.
REQ-013 With no eligible request, it SHALL set gnt <= 0 and q_valid <= 0, and q SHALL hold its value.
REQ-014 The FSM SHALL have states ARB and LOCKED.
REQ-015 In ARB, the winner SHALL be the first asserted req at index ptr, ptr+1, ... (mod N_REQ), giving round-robin order.
REQ-016 In ARB, after a win, ptr SHALL become (winner+1) mod N_REQ; wrap from N_REQ-1 goes to 0.
REQ-017 In ARB, if lock[winner] is high at the winning edge, state SHALL become LOCKED with owner <= winner.
REQ-018 In LOCKED, while req[owner] and lock[owner] are both high, owner SHALL win every edge; ptr SHALL be unchanged; other requests SHALL be ignored.
REQ-019 In LOCKED, if req[owner] or lock[owner] is low at an edge, state SHALL return to ARB. That same edge SHALL arbitrate per REQ-015, so no idle cycle is inserted.
REQ-020 In LOCKED, lock asserted by a non-owner SHALL have no effect.
REQ-021 Grant latency SHALL be exactly one edge: req sampled at edge k produces gnt/q/q_valid valid after edge k.
REQ-022 gnt SHALL never have more than one bit set.
REQ-023 A single continuous requester without lock SHALL be granted every cycle when alone.

Reset
REQ-024 When reset is high at an edge, the block SHALL set gnt=0, q=0, q_valid=0, ptr=0, state=ARB, owner=0, ignoring req/lock that cycle.
REQ-025 Reset SHALL override mid-burst LOCKED and any pending request with no further grant.
REQ-026 On the first edge after reset deasserts, arbitration SHALL start from ptr=0.

Structure
REQ-027 Package reg_arb_pkg SHALL hold the defaults N_REQ_DEF=4 and WIDTH_DEF=8, and the state enum arb_state_t {ARB, LOCKED}.
REQ-028 The rotate-priority search SHALL be one combinational sub-module, rr_pick. Inputs: req, ptr. Outputs: found, index.
REQ-029 All registers (q, gnt, q_valid, ptr, state, owner) SHALL live in shared_reg_arbiter in a single clocked process.

Verification
REQ-030 Reset scenario: after reset, req=4'b1111, no lock, 4 edges -> gnt sequence 0001, 0010, 0100, 1000; q follows wdata[0..3]; ptr wraps to 0.
REQ-031 Lock scenario: ptr=0, req=4'b0011, lock=4'b0001, wdata[0]=8'hA5, 3 edges -> gnt=0001 each edge, q=A5. Dropping lock[0] -> next edge gnt=0010.
REQ-032 Idle scenario: req drops to 0 after q=8'h3C -> gnt=0, q_valid=0, q stays 3C.
REQ-033 Wrap scenario: ptr=3 and req=4'b1001 -> gnt=1000, then gnt=0001.
REQ-034 Reset-in-LOCKED scenario: reset high for 1 cycle during LOCKED owner=2 -> gnt=0, q=0, state=ARB. Next grant with req=4'b0100 -> gnt=0100 from ptr=0.
REQ-035 Continuous checks: gnt is one-hot-or-zero, and q_valid==|gnt on every cycle.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared definitions for the shared register arbiter
//
// Purpose: default sizes, the arbiter state encoding and a pointer-width
// helper used by shared_reg_arbiter and rr_pick.
// Ports:   none (package).
package reg_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to hold a requester index; never less than one.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority requester search
//
// Purpose: find the first asserted request scanning ptr, ptr+1, ... modulo
//          N_REQ.
// Ports:   req   - per-requester request vector
//          ptr   - index holding highest priority this cycle (< N_REQ)
//          found - at least one request is asserted
//          index - winning requester index (0 when found is low)
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [ptr_width(N_REQ)-1:0] ptr,
    output logic                        found,
    output logic [ptr_width(N_REQ)-1:0] index
);

    localparam int PW = ptr_width(N_REQ);

    int k;

    always_comb begin
        found = 1'b0;
        index = '0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr is always below N_REQ, so one subtraction completes the modulo.
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!found && req[k[PW-1:0]]) begin
                found = 1'b1;
                index = k[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter writing one shared register
//
// Purpose: each edge picks at most one requester, loads its write data into
//          the shared register and reports a one-hot grant. A winner that
//          also raises lock keeps the register for as long as it holds both
//          req and lock.
// Ports:   clk     - rising-edge clock
//          reset   - synchronous active-high reset
//          req     - per-requester write request
//          lock    - per-requester burst hold, sampled with req
//          wdata   - per-requester write data
//          gnt     - registered one-hot grant (or zero) for the last write
//          q       - shared register contents
//          q_valid - q was loaded on the last edge
module shared_reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             lock,
    input  logic [N_REQ-1:0][WIDTH-1:0]  wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid
);

    localparam int PW = ptr_width(N_REQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    arb_state_t      state;
    arb_state_t      state_n;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_n;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   owner_n;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic            win;
    logic [PW-1:0]   winner;
    logic [N_REQ-1:0] gnt_n;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Next-state and winner selection.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        win     = 1'b0;
        winner  = '0;

        if (state == LOCKED && req[owner] && lock[owner]) begin
            // Burst continues: owner wins, rotation is frozen.
            win    = 1'b1;
            winner = owner;
        end else begin
            // Either already arbitrating or the burst just ended; in both
            // cases this edge arbitrates normally so no idle cycle appears.
            state_n = ARB;
            if (pick_found) begin
                win    = 1'b1;
                winner = pick_idx;
                ptr_n  = (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
                if (lock[pick_idx]) begin
                    state_n = LOCKED;
                    owner_n = pick_idx;
                end
            end
        end
    end

    always_comb begin
        gnt_n = '0;
        if (win) begin
            gnt_n[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            gnt     <= gnt_n;
            q_valid <= win;
            if (win) begin
                q <= wdata[winner];
            end
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      lock;
    logic [N-1:0][W-1:0] wdata;
    logic [N-1:0]      gnt;
    logic [W-1:0]      q;
    logic              q_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int           m_ptr;
    bit           m_locked;
    int           m_owner;
    logic [W-1:0] m_q;
    logic [N-1:0] m_gnt;
    logic         m_qv;

    shared_reg_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the arbitration rules to the inputs present at the coming edge.
    task automatic model_edge();
        int  w;
        bit  got;
        w   = 0;
        got = 1'b0;
        if (reset) begin
            m_ptr = 0; m_locked = 1'b0; m_owner = 0;
            m_q = '0; m_gnt = '0; m_qv = 1'b0;
            return;
        end
        if (m_locked && req[m_owner] && lock[m_owner]) begin
            w = m_owner;
            got = 1'b1;
        end else begin
            m_locked = 1'b0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!got && req[k]) begin
                    got = 1'b1;
                    w = k;
                end
            end
            if (got) begin
                m_ptr = (w + 1) % N;
                if (lock[w]) begin
                    m_locked = 1'b1;
                    m_owner = w;
                end
            end
        end
        if (got) begin
            m_gnt = '0;
            m_gnt[w] = 1'b1;
            m_q = wdata[w];
            m_qv = 1'b1;
        end else begin
            m_gnt = '0;
            m_qv = 1'b0;
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(m_qv));
        chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
        chk({tag, ".qv_vs_gnt"}, 32'(q_valid), 32'(|gnt));
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);

        // Reset state.
        cycle("reset");
        chk("reset.gnt_lit", 32'(gnt), 32'h0);
        chk("reset.q_lit", 32'(q), 32'h0);

        // Round-robin sweep from ptr=0 with wrap back to 0.
        reset = 1'b0;
        req = 4'b1111;
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        cycle("rr0"); chk("rr0.gnt_lit", 32'(gnt), 32'h1); chk("rr0.q_lit", 32'(q), 32'h11);
        cycle("rr1"); chk("rr1.gnt_lit", 32'(gnt), 32'h2); chk("rr1.q_lit", 32'(q), 32'h22);
        cycle("rr2"); chk("rr2.gnt_lit", 32'(gnt), 32'h4); chk("rr2.q_lit", 32'(q), 32'h33);
        cycle("rr3"); chk("rr3.gnt_lit", 32'(gnt), 32'h8); chk("rr3.q_lit", 32'(q), 32'h44);
        cycle("rrw"); chk("rrw.gnt_lit", 32'(gnt), 32'h1);

        // Lock burst by requester 0, then release.
        reset = 1'b1; req = '0;
        cycle("lk_rst");
        reset = 1'b0;
        req = 4'b0011; lock = 4'b0001; wdata[0] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            cycle("lk");
            chk("lk.gnt_lit", 32'(gnt), 32'h1);
            chk("lk.q_lit", 32'(q), 32'hA5);
        end
        lock = 4'b0000;
        cycle("lk_rel"); chk("lk_rel.gnt_lit", 32'(gnt), 32'h2);

        // Idle hold.
        req = 4'b0010; wdata[1] = 8'h3C;
        cycle("idle_ld"); chk("idle_ld.q_lit", 32'(q), 32'h3C);
        req = 4'b0000;
        cycle("idle");
        chk("idle.gnt_lit", 32'(gnt), 32'h0);
        chk("idle.qv_lit", 32'(q_valid), 32'h0);
        chk("idle.q_lit", 32'(q), 32'h3C);

        // Wrap from ptr=3.
        reset = 1'b1;
        cycle("wr_rst");
        reset = 1'b0;
        req = 4'b0100;
        cycle("wr_set");
        req = 4'b1001;
        cycle("wr0"); chk("wr0.gnt_lit", 32'(gnt), 32'h8);
        cycle("wr1"); chk("wr1.gnt_lit", 32'(gnt), 32'h1);

        // Reset in the middle of a burst owned by requester 2.
        reset = 1'b1; req = '0;
        cycle("rl_rst0");
        reset = 1'b0;
        req = 4'b0100; lock = 4'b0100;
        cycle("rl_a");
        cycle("rl_b"); chk("rl_b.gnt_lit", 32'(gnt), 32'h4);
        reset = 1'b1;
        cycle("rl_rst");
        chk("rl_rst.gnt_lit", 32'(gnt), 32'h0);
        chk("rl_rst.q_lit", 32'(q), 32'h0);
        reset = 1'b0; lock = 4'b0000;
        cycle("rl_after"); chk("rl_after.gnt_lit", 32'(gnt), 32'h4);
        // ptr must be 3 now (started from 0, won 2); non-owner lock ignored below.
        req = 4'b1111; lock = 4'b1111;
        cycle("rl_next"); chk("rl_next.gnt_lit", 32'(gnt), 32'h8);
        lock = 4'b0100;
        cycle("rl_nonown"); chk("rl_nonown.gnt_lit", 32'(gnt), 32'h1);

        // Randomized traffic against the model.
        lock = '0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            req   = N'($urandom);
            lock  = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
